// File: rtl/mem_arbiter.sv
// Memory arbiter: grants one of dcache fill, icache fill or store-buffer drain
// to a single fixed-latency memory port, with a starvation guard for stores.
module mem_arbiter #(
  parameter int DATA_BITS        = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int LINE_BITS        = 128,
  parameter int MEM_LATENCY      = 4,
  parameter int STB_STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stbReq,
  input  logic [ADDRESS_BITS-1:0] stbAddr,
  input  logic [DATA_BITS-1:0]    stbData,
  output logic                    stbAck,
  input  logic                    icReq,
  input  logic [ADDRESS_BITS-1:0] icAddr,
  output logic                    icAck,
  output logic [LINE_BITS-1:0]    icLine,
  input  logic                    dcReq,
  input  logic [ADDRESS_BITS-1:0] dcAddr,
  output logic                    dcAck,
  output logic [LINE_BITS-1:0]    dcLine,
  output logic                    memEn,
  output logic                    memWe,
  output logic [ADDRESS_BITS-1:0] memAddr,
  output logic [DATA_BITS-1:0]    memWData,
  input  logic [LINE_BITS-1:0]    memRData,
  output logic                    busy
);

  localparam int LINE_OFF  = $clog2(LINE_BITS / 8);
  localparam int WORD_OFF  = $clog2(DATA_BITS / 8);
  localparam logic [ADDRESS_BITS-1:0] LINE_MASK = ~ADDRESS_BITS'((64'd1 << LINE_OFF) - 64'd1);
  localparam logic [ADDRESS_BITS-1:0] WORD_MASK = ~ADDRESS_BITS'((64'd1 << WORD_OFF) - 64'd1);
  localparam logic [3:0] CNT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STB_STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} arbStateT;
  typedef enum logic [1:0] {GNT_NONE, GNT_DC, GNT_IC, GNT_STB} grantT;

  arbStateT                state;
  grantT                   grant;
  grantT                   nextGrant;
  logic [3:0]              cnt;
  logic [7:0]              starveCnt;
  logic [LINE_BITS-1:0]    lineReg;
  logic [ADDRESS_BITS-1:0] nextAddr;

  // Reads normally win; a store that has watched too many reads go by takes the port.
  always_comb begin
    nextGrant = GNT_NONE;
    nextAddr  = '0;
    if (stbReq && starveCnt >= STARVE_MAX) nextGrant = GNT_STB;
    else if (dcReq)                        nextGrant = GNT_DC;
    else if (icReq)                        nextGrant = GNT_IC;
    else if (stbReq)                       nextGrant = GNT_STB;
    case (nextGrant)
      GNT_DC:  nextAddr = dcAddr & LINE_MASK;
      GNT_IC:  nextAddr = icAddr & LINE_MASK;
      GNT_STB: nextAddr = stbAddr & WORD_MASK;
      default: nextAddr = '0;
    endcase
  end

  assign icLine = lineReg;
  assign dcLine = lineReg;

  // memEn/memWe are raised one edge early so they land exactly in the cnt==0 cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      cnt       <= '0;
      starveCnt <= '0;
      lineReg   <= '0;
      memEn     <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      stbAck    <= 1'b0;
      icAck     <= 1'b0;
      dcAck     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      memEn  <= 1'b0;
      memWe  <= 1'b0;
      stbAck <= 1'b0;
      icAck  <= 1'b0;
      dcAck  <= 1'b0;
      case (state)
        IDLE: begin
          if (!stbReq) starveCnt <= '0;
          if (nextGrant != GNT_NONE) begin
            grant    <= nextGrant;
            memAddr  <= nextAddr;
            memWData <= stbData;
            cnt      <= CNT_LOAD;
            state    <= ACCESS;
            busy     <= 1'b1;
            memEn    <= (CNT_LOAD == 4'd0);
            memWe    <= (CNT_LOAD == 4'd0) && (nextGrant == GNT_STB);
            if (nextGrant == GNT_STB)
              starveCnt <= '0;
            else if (stbReq && starveCnt < STARVE_MAX)
              starveCnt <= starveCnt + 8'd1;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt   <= cnt - 4'd1;
            memEn <= (cnt == 4'd1);
            memWe <= (cnt == 4'd1) && (grant == GNT_STB);
          end else begin
            state <= ACK;
            if (grant != GNT_STB) lineReg <= memRData;
            stbAck <= (grant == GNT_STB);
            icAck  <= (grant == GNT_IC);
            dcAck  <= (grant == GNT_DC);
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timestamp-based transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int LAT   = 4;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         stbReq, icReq, dcReq;
  logic [31:0]  stbAddr, stbData, icAddr, dcAddr;
  logic         stbAck, icAck, dcAck;
  logic [127:0] icLine, dcLine, memRData;
  logic         memEn, memWe, busy;
  logic [31:0]  memAddr, memWData;

  logic         dcReq1, stbReq1, icReq1;
  logic [31:0]  dcAddr1, stbAddr1, stbData1, icAddr1;
  logic         stbAck1, icAck1, dcAck1, memEn1, memWe1, busy1;
  logic [127:0] icLine1, dcLine1;
  logic [31:0]  memAddr1, memWData1;

  mem_arbiter #(.MEM_LATENCY(LAT), .STB_STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .stbReq(stbReq), .stbAddr(stbAddr), .stbData(stbData), .stbAck(stbAck),
    .icReq(icReq), .icAddr(icAddr), .icAck(icAck), .icLine(icLine),
    .dcReq(dcReq), .dcAddr(dcAddr), .dcAck(dcAck), .dcLine(dcLine),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .stbReq(stbReq1), .stbAddr(stbAddr1), .stbData(stbData1), .stbAck(stbAck1),
    .icReq(icReq1), .icAddr(icAddr1), .icAck(icAck1), .icLine(icLine1),
    .dcReq(dcReq1), .dcAddr(dcAddr1), .dcAck(dcAck1), .dcLine(dcLine1),
    .memEn(memEn1), .memWe(memWe1), .memAddr(memAddr1), .memWData(memWData1),
    .memRData(memRData), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Model: one transaction at a time, described by its start cycle and grantee.
  int           cyc = 0;
  bit           active = 0;
  int           tStart = 0;
  int           gnt = 0;
  int           starve = 0;
  bit           everGranted = 0;
  logic [31:0]  mAddr = '0, mData = '0;
  logic [127:0] mLine = '0;

  always @(posedge clk) begin
    bit expEn, expAckCyc;
    if (rst) begin
      active = 0; starve = 0; mLine = '0; everGranted = 0;
    end else if (active) begin
      if (cyc == tStart + LAT && gnt != 3) mLine = memRData;
      if (cyc == tStart + LAT + 1) active = 0;
    end else begin
      if (!stbReq) starve = 0;
      gnt = 0;
      if (stbReq && starve >= LIMIT) gnt = 3;
      else if (dcReq)                gnt = 1;
      else if (icReq)                gnt = 2;
      else if (stbReq)               gnt = 3;
      if (gnt != 0) begin
        active = 1; tStart = cyc; everGranted = 1;
        if (gnt == 1)      mAddr = dcAddr & ~32'hF;
        else if (gnt == 2) mAddr = icAddr & ~32'hF;
        else               mAddr = stbAddr & ~32'h3;
        mData = stbData;
        if (gnt == 3)    starve = 0;
        else if (stbReq) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
      end
    end
    cyc++;
    #1;
    expEn     = active && (cyc == tStart + LAT);
    expAckCyc = active && (cyc == tStart + LAT + 1);
    checkOutput("memEn", memEn, expEn);
    checkOutput("memWe", memWe, expEn && gnt == 3);
    checkOutput("busy", busy, active);
    checkOutput("stbAck", stbAck, expAckCyc && gnt == 3);
    checkOutput("icAck", icAck, expAckCyc && gnt == 2);
    checkOutput("dcAck", dcAck, expAckCyc && gnt == 1);
    if (expEn) checkOutput("memAddr", memAddr, mAddr);
    if (expEn && gnt == 3) checkOutput("memWData", memWData, mData);
    if (expAckCyc && gnt == 1) checkOutput("dcLine", dcLine, mLine);
    if (expAckCyc && gnt == 2) checkOutput("icLine", icLine, mLine);
    if (!everGranted) begin
      checkOutput("idleAddr", memAddr, 0);
      checkOutput("idleWData", memWData, 0);
    end
  end

  task automatic applyStimulus();
    int readAcks;
    bit seen;
    rst = 1; stbReq = 0; icReq = 0; dcReq = 0;
    stbAddr = '0; stbData = '0; icAddr = '0; dcAddr = '0; memRData = '0;
    dcReq1 = 0; stbReq1 = 0; icReq1 = 0;
    dcAddr1 = '0; stbAddr1 = '0; stbData1 = '0; icAddr1 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstMemEn", memEn, 0);
    checkOutput("rstAddr", memAddr, 0);
    checkOutput("rstLine", dcLine, 0);
    rst = 0;
    @(negedge clk);

    // Store: addr 0x103 aligns to 0x100
    stbAddr = 32'h103; stbData = 32'hDEADBEEF; stbReq = 1;
    repeat (4) @(negedge clk);
    checkOutput("stEn", memEn, 1);
    checkOutput("stWe", memWe, 1);
    checkOutput("stAddr", memAddr, 32'h100);
    checkOutput("stWData", memWData, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("stAck", stbAck, 1);
    stbReq = 0; stbAddr = 32'h555;
    @(negedge clk);

    // dc beats ic; ic follows after one idle cycle
    memRData = {16{8'hA5}}; dcAddr = 32'h2C; dcReq = 1; icAddr = 32'h1234567F; icReq = 1;
    repeat (4) @(negedge clk);
    checkOutput("dcMemAddr", memAddr, 32'h20);
    checkOutput("dcWe", memWe, 0);
    @(negedge clk);
    checkOutput("dcAckLit", dcAck, 1);
    checkOutput("dcLineLit", dcLine, {16{8'hA5}});
    checkOutput("icAckEarly", icAck, 0);
    dcReq = 0; memRData = {4{32'h0BADF00D}};
    @(negedge clk);
    checkOutput("gapBusy", busy, 0);
    repeat (4) @(negedge clk);
    checkOutput("icMemAddr", memAddr, 32'h12345670);
    @(negedge clk);
    checkOutput("icAckLit", icAck, 1);
    checkOutput("icLineLit", icLine, {4{32'h0BADF00D}});
    icReq = 0;
    @(negedge clk);

    // Store starvation guard
    stbAddr = 32'hFFFFFFFF; stbData = 32'h13579BDF; stbReq = 1;
    dcAddr = 32'h40; dcReq = 1; icAddr = 32'h80; icReq = 0;
    readAcks = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (dcAck) begin readAcks++; dcReq = 0; icReq = 1; end
      else if (icAck) begin readAcks++; icReq = 0; dcReq = 1; end
      else if (stbAck) begin seen = 1; stbReq = 0; dcReq = 0; icReq = 0; end
    end
    checkOutput("stbGranted", seen, 1);
    checkOutput("readsBeforeStb", readAcks, 4);
    stbReq = 0; dcReq = 0; icReq = 0;
    @(negedge clk);

    // Reset in the middle of an ic access
    icAddr = 32'h300; icReq = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checkOutput("rstMidBusy", busy, 0);
    rst = 0; icReq = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput("rstNoEn", memEn, 0);
      checkOutput("rstNoAck", icAck, 0);
    end

    // Latency 1 instance, request dropped mid-access
    dcAddr1 = 32'h1F4; dcReq1 = 1; memRData = {4{32'hCAFEF00D}};
    @(negedge clk);
    checkOutput("l1En", memEn1, 1);
    checkOutput("l1Addr", memAddr1, 32'h1F0);
    checkOutput("l1AckEarly", dcAck1, 0);
    dcReq1 = 0;
    @(negedge clk);
    checkOutput("l1Ack", dcAck1, 1);
    checkOutput("l1Line", dcLine1, {4{32'hCAFEF00D}});
    @(negedge clk);
    checkOutput("l1AckDone", dcAck1, 0);
    checkOutput("l1Busy", busy1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
